// File: rtl/rpi_link_reader.sv
// rpi_link_reader: polls the FPGA->Pi output link, strobes the sender FIFO and
// turns address/data word pairs into ISA port-write transactions.
module rpi_link_reader #(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned POLL_GAP      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] link_q,
  input  logic       link_has_data,
  output logic       link_rdclk,
  output logic       link_inc,
  output logic       tx_valid,
  output logic [7:0] tx_port,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [7:0] err_cnt
);

  localparam int unsigned MaxCnt = (STROBE_CYCLES > POLL_GAP) ? STROBE_CYCLES : POLL_GAP;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] StrobeLast = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StRclkHi, StRclkLo, StIncHi, StIncLo, StDecode, StEmit
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [8:0] word_s1_q, word_s2_q, word_q;
  logic       hd_s1_q, hd_s2_q, hd_q;

  logic [7:0] cur_port_q;
  logic       port_ok_q;
  logic       addr_pending_q;  // address seen but not yet used by a data word

  logic       rdclk_q, inc_q, tx_valid_q;
  logic [7:0] tx_port_q, tx_data_q, err_cnt_q;

  logic strobe_done, capture, is_addr, emit_go, err_hit;

  assign strobe_done = (cnt_q == StrobeLast);
  assign capture     = (state_q == StRclkHi) && strobe_done;
  assign is_addr     = word_q[8];
  assign emit_go     = (state_q == StDecode) && !is_addr && port_ok_q;
  assign err_hit     = (state_q == StDecode) &&
                       (is_addr ? (port_ok_q && addr_pending_q) : !port_ok_q);

  // Two-flop synchronizers for the asynchronous link inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_s1_q <= '0;
      word_s2_q <= '0;
      hd_s1_q   <= 1'b0;
      hd_s2_q   <= 1'b0;
    end else begin
      word_s1_q <= link_q;
      word_s2_q <= word_s1_q;
      hd_s1_q   <= link_has_data;
      hd_s2_q   <= hd_s1_q;
    end
  end

  // Next-state logic; the phase counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (cnt_q == GapLast) begin
          state_d = StRclkHi;
          cnt_d   = '0;
        end
      end
      StRclkHi: begin
        if (strobe_done) begin
          state_d = StRclkLo;
          cnt_d   = '0;
        end
      end
      StRclkLo: begin
        if (strobe_done) begin
          state_d = hd_q ? StIncHi : StIdle;
          cnt_d   = '0;
        end
      end
      StIncHi: begin
        if (strobe_done) begin
          state_d = StIncLo;
          cnt_d   = '0;
        end
      end
      StIncLo: begin
        if (strobe_done) begin
          state_d = StDecode;
          cnt_d   = '0;
        end
      end
      StDecode: begin
        cnt_d   = '0;
        state_d = emit_go ? StEmit : StIdle;
      end
      StEmit: begin
        cnt_d = '0;
        if (tx_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word capture at the end of the read-clock high phase, then decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q         <= '0;
      hd_q           <= 1'b0;
      cur_port_q     <= '0;
      port_ok_q      <= 1'b0;
      addr_pending_q <= 1'b0;
      tx_port_q      <= '0;
      tx_data_q      <= '0;
      err_cnt_q      <= '0;
    end else begin
      if (capture) begin
        word_q <= word_s2_q;
        hd_q   <= hd_s2_q;
      end
      if (state_q == StDecode && is_addr) begin
        cur_port_q     <= word_q[7:0];
        port_ok_q      <= 1'b1;
        addr_pending_q <= 1'b1;
      end
      if (emit_go) begin
        tx_port_q      <= cur_port_q;
        tx_data_q      <= word_q[7:0];
        addr_pending_q <= 1'b0;
      end
      if (err_hit && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Registered strobes and valid, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdclk_q    <= 1'b0;
      inc_q      <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      rdclk_q    <= (state_d == StRclkHi);
      inc_q      <= (state_d == StIncHi);
      tx_valid_q <= (state_d == StEmit);
    end
  end

  assign link_rdclk = rdclk_q;
  assign link_inc   = inc_q;
  assign tx_valid   = tx_valid_q;
  assign tx_port    = tx_port_q;
  assign tx_data    = tx_data_q;
  assign err_cnt    = err_cnt_q;

endmodule
